flow_table_loader: RTL and testbench
====================================

// Module: flow_table_loader
// PURPOSE
// - Control-plane writer for one flow_table stage: accepts entry commands, sequences TCAM and action-table writes into the shadow bank, then commits by toggling flow_buffer_sel.
// - Sits between the blueswitch register block (command source) and the stage's tcam_*/action_* write ports; one instance per flow table.
// PARAMETERS
// - TBL_ADDR_WIDTH      4   entry address width
// - TCAM_DATA_WIDTH     32  TCAM key/mask width
// - ACT_TBL_DATA_WIDTH  8   action word width
// - BUSY_TIMEOUT        64  cycles allowed for tcam_busy to clear (only with FLOW_LOADER_TIMEOUT_EN)
// - CNT_WIDTH           32  status counter width
// PORTS
// - axi_aclk         in   1    clock
// - axi_resetn       in   1    asynchronous reset, active-low
// - s_cmd_op         in   2    00 entry wr, 01 commit, 10 action-only wr, 11 reserved
// - s_cmd_addr       in   TBL_ADDR_WIDTH     entry index
// - s_cmd_key        in   TCAM_DATA_WIDTH    TCAM data
// - s_cmd_mask       in   TCAM_DATA_WIDTH    TCAM mask
// - s_cmd_act        in   ACT_TBL_DATA_WIDTH action word
// - s_cmd_valid      in   1    command valid
// - s_cmd_ready      out  1    command accepted when valid&ready
// - tcam_addr_wr     out  TBL_ADDR_WIDTH; tcam_din/tcam_din_mask out TCAM_DATA_WIDTH
// - tcam_wren        out  1    single-cycle write pulse
// - tcam_busy        in   1    TCAM write in progress
// - tcam_wr_ctrl     out  2    01 while writing shadow bank, 00 otherwise
// - action_addr_wr   out  TBL_ADDR_WIDTH; action_din out ACT_TBL_DATA_WIDTH
// - action_wren      out  1    single-cycle write pulse
// - action_wr_ctrl   out  2    01 while writing shadow bank, 00 otherwise
// - flow_buffer_sel  out  1    active bank select, toggles on commit
// - loader_busy      out  1    FSM not IDLE
// - wr_count         out  CNT_WIDTH  completed entry/action writes (wraps)
// - err_count        out  CNT_WIDTH  reserved ops + timeouts (saturates)
// BEHAVIOUR
// - Reset: all outputs 0; s_cmd_ready 0 in reset; FSM IDLE; flow_buffer_sel 0.
// - s_cmd_ready = (state==IDLE); command fields registered on accept.
// - FSM: IDLE -> T_WR (op 00) | A_WR (op 10) | COMMIT (op 01) | IDLE (op 11, err_count+1, no write).
// - T_WR: tcam_wren=1 one cycle, addr/din/mask held stable from T_WR to end of T_WAIT -> T_WAIT.
// - T_WAIT: exit when tcam_busy==0 and >=2 cycles since wren -> A_WR.
// - A_WR: action_wren=1 one cycle -> DONE.
// - COMMIT: wait tcam_busy==0, toggle flow_buffer_sel -> DONE.
// - DONE: one cycle, wr_count+1 for write ops only -> IDLE.
// - Latency, entry write with idle TCAM: accept -> tcam_wren 1 cycle later, action_wren 3 cycles after tcam_wren.
// - Action-only write: accept -> action_wren 1 cycle later.
// - wr_ctrl outputs 01 from T_WR through DONE of write ops; 00 in IDLE/COMMIT.
// - tcam_busy high in IDLE: commands still accepted; T_WR issues anyway (TCAM queues).
// - wr_count wraps at 2^CNT_WIDTH; err_count holds at all-ones.
// - Reset mid-sequence: immediate return to IDLE, pulses drop same edge, partial entry not completed, bank select back to 0.
// CONFIGURATION
// - FLOW_LOADER_TIMEOUT_EN defined: cycle counter in T_WAIT/COMMIT.
//   - Reaching BUSY_TIMEOUT with tcam_busy still 1: err_count+1, action write skipped, commit skipped, -> DONE without wr_count increment.
// - FLOW_LOADER_TIMEOUT_EN undefined: waits indefinitely; BUSY_TIMEOUT unused; err_count counts only reserved ops.
// TESTING
// - op00 addr=3 key=32'h0a000001 mask=32'hffffff00 act=8'h04, busy 2 cycles
//   -> one tcam_wren, one action_wren at addr 3, wr_count=1, wr_ctrl=01 during write.
// - op10 addr=15 act=8'h80 -> action_wren 1 cycle after accept, no tcam_wren, wr_count+1.
// - op01 twice -> flow_buffer_sel 0->1->0, wr_count unchanged.
// - op11 -> no write pulses, err_count=1, s_cmd_ready back high after 1 cycle.
// - busy stuck 1 with FLOW_LOADER_TIMEOUT_EN, BUSY_TIMEOUT=64
//   -> no action_wren, err_count=1, IDLE after ~66 cycles.
//   Without the macro the FSM stays in T_WAIT.
// - axi_resetn low during T_WAIT -> all outputs 0 same edge, next command processed normally.

Source files
------------

// File: rtl/flow_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : flow_table_loader
// Description : Control-plane writer for one flow_table stage. Accepts entry,
//               action-only and commit commands, sequences TCAM and action
//               table writes into the shadow bank, and commits by toggling
//               flow_buffer_sel.
// Options     : FLOW_LOADER_TIMEOUT_EN - when defined, T_WAIT/COMMIT give up
//               after BUSY_TIMEOUT cycles of tcam_busy and count an error.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_table_loader #(
   parameter int TBL_ADDR_WIDTH     = 4,
   parameter int TCAM_DATA_WIDTH    = 32,
   parameter int ACT_TBL_DATA_WIDTH = 8,
   parameter int BUSY_TIMEOUT       = 64,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                          axi_aclk,
   input  logic                          axi_resetn,
   input  logic [1:0]                    s_cmd_op,
   input  logic [TBL_ADDR_WIDTH-1:0]     s_cmd_addr,
   input  logic [TCAM_DATA_WIDTH-1:0]    s_cmd_key,
   input  logic [TCAM_DATA_WIDTH-1:0]    s_cmd_mask,
   input  logic [ACT_TBL_DATA_WIDTH-1:0] s_cmd_act,
   input  logic                          s_cmd_valid,
   output logic                          s_cmd_ready,
   output logic [TBL_ADDR_WIDTH-1:0]     tcam_addr_wr,
   output logic [TCAM_DATA_WIDTH-1:0]    tcam_din,
   output logic [TCAM_DATA_WIDTH-1:0]    tcam_din_mask,
   output logic                          tcam_wren,
   input  logic                          tcam_busy,
   output logic [1:0]                    tcam_wr_ctrl,
   output logic [TBL_ADDR_WIDTH-1:0]     action_addr_wr,
   output logic [ACT_TBL_DATA_WIDTH-1:0] action_din,
   output logic                          action_wren,
   output logic [1:0]                    action_wr_ctrl,
   output logic                          flow_buffer_sel,
   output logic                          loader_busy,
   output logic [CNT_WIDTH-1:0]          wr_count,
   output logic [CNT_WIDTH-1:0]          err_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_T_WR   = 3'd1,
      S_T_WAIT = 3'd2,
      S_A_WR   = 3'd3,
      S_COMMIT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [1:0] c_OP_ENTRY    = 2'b00;
   localparam logic [1:0] c_OP_COMMIT   = 2'b01;
   localparam logic [1:0] c_OP_ACT      = 2'b10;
   localparam logic [1:0] c_CTRL_SHADOW = 2'b01;
   localparam logic [1:0] c_CTRL_NONE   = 2'b00;
   // Wide enough to count BUSY_TIMEOUT wait cycles; also serves the 2-cycle gap.
   localparam int         c_WCNT_W      = $clog2(BUSY_TIMEOUT) + 1;

   state_t                          r_state;
   state_t                          w_next;
   logic                            r_rst_done;
   logic [1:0]                      r_op;
   logic [TBL_ADDR_WIDTH-1:0]       r_addr;
   logic [TCAM_DATA_WIDTH-1:0]      r_key;
   logic [TCAM_DATA_WIDTH-1:0]      r_mask;
   logic [ACT_TBL_DATA_WIDTH-1:0]   r_act;
   logic [c_WCNT_W-1:0]             r_wait_cnt;
   logic                            r_timed_out;
   logic                            r_bank;
   logic [CNT_WIDTH-1:0]            r_wr_count;
   logic [CNT_WIDTH-1:0]            r_err_count;
   logic                            w_accept;
   logic                            w_min_gap;
   logic                            w_busy_timeout;
   logic                            w_toggle;
   logic                            w_reserved;
   logic                            w_set_timeout;

   // Ready is held low in reset and for the first edge after it.
   assign s_cmd_ready = (r_state == S_IDLE) && r_rst_done;
   assign w_accept    = s_cmd_valid && s_cmd_ready;
   // At least two cycles since tcam_wren: T_WR plus one full T_WAIT cycle.
   assign w_min_gap   = (r_wait_cnt != '0);

`ifdef FLOW_LOADER_TIMEOUT_EN
   assign w_busy_timeout = tcam_busy &&
                           (r_wait_cnt == c_WCNT_W'(BUSY_TIMEOUT - 1));
`else
   assign w_busy_timeout = 1'b0;
`endif

   assign tcam_addr_wr    = r_addr;
   assign tcam_din        = r_key;
   assign tcam_din_mask   = r_mask;
   assign action_addr_wr  = r_addr;
   assign action_din      = r_act;
   assign flow_buffer_sel = r_bank;
   assign loader_busy     = (r_state != S_IDLE);
   assign wr_count        = r_wr_count;
   assign err_count       = r_err_count;

   // State register; reset aborts any partial sequence.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) r_state <= S_IDLE;
      else             r_state <= w_next;
   end

   // Next-state decode and per-state write strobes.
   always_comb begin
      w_next         = r_state;
      w_toggle       = 1'b0;
      w_reserved     = 1'b0;
      w_set_timeout  = 1'b0;
      tcam_wren      = 1'b0;
      action_wren    = 1'b0;
      tcam_wr_ctrl   = c_CTRL_NONE;
      action_wr_ctrl = c_CTRL_NONE;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (s_cmd_op)
                  c_OP_ENTRY:  w_next = S_T_WR;
                  c_OP_COMMIT: w_next = S_COMMIT;
                  c_OP_ACT:    w_next = S_A_WR;
                  default:     w_reserved = 1'b1;
               endcase
            end
         end
         S_T_WR: begin
            tcam_wren      = 1'b1;
            tcam_wr_ctrl   = c_CTRL_SHADOW;
            action_wr_ctrl = c_CTRL_SHADOW;
            w_next         = S_T_WAIT;
         end
         S_T_WAIT: begin
            tcam_wr_ctrl   = c_CTRL_SHADOW;
            action_wr_ctrl = c_CTRL_SHADOW;
            if (!tcam_busy && w_min_gap) begin
               w_next = S_A_WR;
            end else if (w_busy_timeout) begin
               w_next        = S_DONE;
               w_set_timeout = 1'b1;
            end
         end
         S_A_WR: begin
            action_wren    = 1'b1;
            tcam_wr_ctrl   = c_CTRL_SHADOW;
            action_wr_ctrl = c_CTRL_SHADOW;
            w_next         = S_DONE;
         end
         S_COMMIT: begin
            if (!tcam_busy) begin
               w_toggle = 1'b1;
               w_next   = S_DONE;
            end else if (w_busy_timeout) begin
               w_next        = S_DONE;
               w_set_timeout = 1'b1;
            end
         end
         S_DONE: begin
            if (r_op != c_OP_COMMIT) begin
               tcam_wr_ctrl   = c_CTRL_SHADOW;
               action_wr_ctrl = c_CTRL_SHADOW;
            end
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture command fields on accept; they stay stable for the whole sequence.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_op   <= '0;
         r_addr <= '0;
         r_key  <= '0;
         r_mask <= '0;
         r_act  <= '0;
      end else if (w_accept) begin
         r_op   <= s_cmd_op;
         r_addr <= s_cmd_addr;
         r_key  <= s_cmd_key;
         r_mask <= s_cmd_mask;
         r_act  <= s_cmd_act;
      end
   end

   // Cycles spent in the current wait state, restarted on every state change.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_wait_cnt <= '0;
      end else if (w_next != r_state) begin
         r_wait_cnt <= '0;
      end else if (((r_state == S_T_WAIT) || (r_state == S_COMMIT)) &&
                   (r_wait_cnt != '1)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Timeout flag suppresses the wr_count update in DONE.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn)        r_timed_out <= 1'b0;
      else if (w_accept)      r_timed_out <= 1'b0;
      else if (w_set_timeout) r_timed_out <= 1'b1;
   end

   // Bank select, counters and the post-reset ready qualifier.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_bank      <= 1'b0;
         r_wr_count  <= '0;
         r_err_count <= '0;
         r_rst_done  <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         if (w_toggle) r_bank <= ~r_bank;
         if ((r_state == S_DONE) && (r_op != c_OP_COMMIT) && !r_timed_out)
            r_wr_count <= r_wr_count + 1'b1;
         if ((w_reserved || w_set_timeout) && (r_err_count != '1))
            r_err_count <= r_err_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flow_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_table_loader
// Description : Directed self-checking bench for flow_table_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_table_loader;

   localparam int AW   = 4;
   localparam int DW   = 32;
   localparam int ACTW = 8;
   localparam int CW   = 32;

   logic            axi_aclk   = 1'b0;
   logic            axi_resetn = 1'b0;
   logic [1:0]      s_cmd_op   = '0;
   logic [AW-1:0]   s_cmd_addr = '0;
   logic [DW-1:0]   s_cmd_key  = '0;
   logic [DW-1:0]   s_cmd_mask = '0;
   logic [ACTW-1:0] s_cmd_act  = '0;
   logic            s_cmd_valid = 1'b0;
   logic            s_cmd_ready;
   logic [AW-1:0]   tcam_addr_wr;
   logic [DW-1:0]   tcam_din;
   logic [DW-1:0]   tcam_din_mask;
   logic            tcam_wren;
   logic            tcam_busy = 1'b0;
   logic [1:0]      tcam_wr_ctrl;
   logic [AW-1:0]   action_addr_wr;
   logic [ACTW-1:0] action_din;
   logic            action_wren;
   logic [1:0]      action_wr_ctrl;
   logic            flow_buffer_sel;
   logic            loader_busy;
   logic [CW-1:0]   wr_count;
   logic [CW-1:0]   err_count;

   flow_table_loader #(
      .TBL_ADDR_WIDTH     (AW),
      .TCAM_DATA_WIDTH    (DW),
      .ACT_TBL_DATA_WIDTH (ACTW),
      .BUSY_TIMEOUT       (64),
      .CNT_WIDTH          (CW)
   ) dut (
      .axi_aclk        (axi_aclk),
      .axi_resetn      (axi_resetn),
      .s_cmd_op        (s_cmd_op),
      .s_cmd_addr      (s_cmd_addr),
      .s_cmd_key       (s_cmd_key),
      .s_cmd_mask      (s_cmd_mask),
      .s_cmd_act       (s_cmd_act),
      .s_cmd_valid     (s_cmd_valid),
      .s_cmd_ready     (s_cmd_ready),
      .tcam_addr_wr    (tcam_addr_wr),
      .tcam_din        (tcam_din),
      .tcam_din_mask   (tcam_din_mask),
      .tcam_wren       (tcam_wren),
      .tcam_busy       (tcam_busy),
      .tcam_wr_ctrl    (tcam_wr_ctrl),
      .action_addr_wr  (action_addr_wr),
      .action_din      (action_din),
      .action_wren     (action_wren),
      .action_wr_ctrl  (action_wr_ctrl),
      .flow_buffer_sel (flow_buffer_sel),
      .loader_busy     (loader_busy),
      .wr_count        (wr_count),
      .err_count       (err_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [CW-1:0] exp_wr  = '0;
   logic [CW-1:0] exp_err = '0;

   // Observation record of the latest window.
   int              tw_first, tw_cnt, aw_first, aw_cnt;
   logic [AW-1:0]   tw_addr, aw_addr;
   logic [DW-1:0]   tw_key, tw_mask;
   logic [ACTW-1:0] aw_din;
   logic [1:0]      ctrl_at [0:127];
   logic [1:0]      actl_at [0:127];
   logic            sel_at  [0:127];
   logic            rdy_at  [0:127];
   logic            lb_at   [0:127];

   // Drive one command; returns one time unit after the accepting edge.
   task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [DW-1:0] k, input logic [DW-1:0] m,
                            input logic [ACTW-1:0] act);
      s_cmd_op    = op;
      s_cmd_addr  = a;
      s_cmd_key   = k;
      s_cmd_mask  = m;
      s_cmd_act   = act;
      s_cmd_valid = 1'b1;
      @(posedge axi_aclk);
      #1;
      s_cmd_valid = 1'b0;
   endtask

   // Run n cycles after accept; tcam_busy high for cycles blo..bhi.
   task automatic run_window(input int n, input int blo, input int bhi);
      tw_first = -1; tw_cnt = 0; aw_first = -1; aw_cnt = 0;
      for (int k = 1; k <= n; k++) begin
         tcam_busy = (k >= blo) && (k <= bhi);
         @(negedge axi_aclk);
         if (tcam_wren) begin
            if (tw_first < 0) tw_first = k;
            tw_cnt++;
            tw_addr = tcam_addr_wr;
            tw_key  = tcam_din;
            tw_mask = tcam_din_mask;
         end
         if (action_wren) begin
            if (aw_first < 0) aw_first = k;
            aw_cnt++;
            aw_addr = action_addr_wr;
            aw_din  = action_din;
         end
         ctrl_at[k] = tcam_wr_ctrl;
         actl_at[k] = action_wr_ctrl;
         sel_at[k]  = flow_buffer_sel;
         rdy_at[k]  = s_cmd_ready;
         lb_at[k]   = loader_busy;
         @(posedge axi_aclk);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [2*CW+9:0] obs;
      repeat (2) @(posedge axi_aclk);
      #1;
      obs = {s_cmd_ready, tcam_wren, action_wren, flow_buffer_sel, loader_busy,
             tcam_wr_ctrl, action_wr_ctrl, tcam_addr_wr == '0, wr_count, err_count};
      n_cmp++;
      if (obs !== {10'b0, {2*CW{1'b0}}} && !(obs[2*CW] === 1'b1 && obs[2*CW+9:2*CW+1] === 9'b0 &&
          obs[2*CW-1:0] === '0)) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required all zero", obs);
      end
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      @(posedge axi_aclk);
      #1;
      n_cmp++;
      if (s_cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b required 1", s_cmd_ready);
      end
   endtask

   task automatic test_entry_write();
      issue_cmd(2'b00, 4'd3, 32'h0a000001, 32'hffffff00, 8'h04);
      run_window(10, 2, 3);
      exp_wr = exp_wr + 1;
      n_cmp++;
      if (tw_cnt !== 1 || tw_first !== 1) begin
         n_fail++; $display("FAIL entry_tcam_wren: got cnt %0d at %0d required 1 at 1", tw_cnt, tw_first);
      end
      n_cmp++;
      if ({tw_addr, tw_key, tw_mask} !== {4'd3, 32'h0a000001, 32'hffffff00}) begin
         n_fail++; $display("FAIL entry_tcam_data: got %h %h %h", tw_addr, tw_key, tw_mask);
      end
      n_cmp++;
      if (aw_cnt !== 1 || aw_first !== 5) begin
         n_fail++; $display("FAIL entry_action_wren: got cnt %0d at %0d required 1 at 5", aw_cnt, aw_first);
      end
      n_cmp++;
      if ({aw_addr, aw_din} !== {4'd3, 8'h04}) begin
         n_fail++; $display("FAIL entry_action_data: got %h %h required 3 04", aw_addr, aw_din);
      end
      n_cmp++;
      if ({ctrl_at[1], ctrl_at[3], ctrl_at[6], actl_at[5], ctrl_at[7]} !== 10'b01_01_01_01_00) begin
         n_fail++; $display("FAIL entry_wr_ctrl: got %b %b %b %b %b required 01 01 01 01 00",
                            ctrl_at[1], ctrl_at[3], ctrl_at[6], actl_at[5], ctrl_at[7]);
      end
      n_cmp++;
      if ({rdy_at[3], rdy_at[6], rdy_at[7]} !== 3'b001) begin
         n_fail++; $display("FAIL entry_ready: got %b%b%b required 001", rdy_at[3], rdy_at[6], rdy_at[7]);
      end
      n_cmp++;
      if (wr_count !== exp_wr) begin
         n_fail++; $display("FAIL entry_wr_count: got %0d required %0d", wr_count, exp_wr);
      end
   endtask

   task automatic test_entry_latency();
      issue_cmd(2'b00, 4'd9, 32'h12345678, 32'hffffffff, 8'h5a);
      run_window(8, 100, 0);
      exp_wr = exp_wr + 1;
      n_cmp++;
      if (tw_first !== 1 || aw_first !== 4) begin
         n_fail++; $display("FAIL latency_idle_tcam: got tcam %0d action %0d required 1 4", tw_first, aw_first);
      end
      n_cmp++;
      if ({aw_addr, aw_din, wr_count} !== {4'd9, 8'h5a, exp_wr}) begin
         n_fail++; $display("FAIL latency_data: got %h %h %0d required 9 5a %0d", aw_addr, aw_din, wr_count, exp_wr);
      end
   endtask

   task automatic test_action_only();
      issue_cmd(2'b10, 4'd15, 32'hdeadbeef, 32'h0, 8'h80);
      run_window(5, 100, 0);
      exp_wr = exp_wr + 1;
      n_cmp++;
      if (aw_first !== 1 || aw_cnt !== 1 || tw_cnt !== 0) begin
         n_fail++; $display("FAIL action_only_pulses: got aw %0d@%0d tw %0d required 1@1 0", aw_cnt, aw_first, tw_cnt);
      end
      n_cmp++;
      if ({aw_addr, aw_din, actl_at[1], actl_at[2]} !== {4'hf, 8'h80, 2'b01, 2'b01}) begin
         n_fail++; $display("FAIL action_only_data: got %h %h %b %b", aw_addr, aw_din, actl_at[1], actl_at[2]);
      end
      n_cmp++;
      if (wr_count !== exp_wr) begin
         n_fail++; $display("FAIL action_only_wr_count: got %0d required %0d", wr_count, exp_wr);
      end
   endtask

   task automatic test_commit();
      issue_cmd(2'b01, 4'd0, 32'h0, 32'h0, 8'h0);
      run_window(4, 100, 0);
      n_cmp++;
      if ({sel_at[1], sel_at[2], ctrl_at[1], actl_at[2]} !== {1'b0, 1'b1, 2'b00, 2'b00}) begin
         n_fail++; $display("FAIL commit1_sel: got sel %b->%b ctrl %b %b required 0->1 00 00",
                            sel_at[1], sel_at[2], ctrl_at[1], actl_at[2]);
      end
      issue_cmd(2'b01, 4'd0, 32'h0, 32'h0, 8'h0);
      run_window(4, 100, 0);
      n_cmp++;
      if ({sel_at[1], sel_at[2]} !== 2'b10) begin
         n_fail++; $display("FAIL commit2_sel: got %b->%b required 1->0", sel_at[1], sel_at[2]);
      end
      n_cmp++;
      if (wr_count !== exp_wr || tw_cnt !== 0 || aw_cnt !== 0) begin
         n_fail++; $display("FAIL commit_no_write: got wr_count %0d tw %0d aw %0d required %0d 0 0",
                            wr_count, tw_cnt, aw_cnt, exp_wr);
      end
      // Commit while the TCAM is still busy waits for it to clear.
      issue_cmd(2'b01, 4'd0, 32'h0, 32'h0, 8'h0);
      run_window(7, 1, 3);
      n_cmp++;
      if ({sel_at[4], sel_at[5]} !== 2'b01) begin
         n_fail++; $display("FAIL commit_busy_sel: got %b->%b required 0->1", sel_at[4], sel_at[5]);
      end
   endtask

   task automatic test_reserved();
      issue_cmd(2'b11, 4'd5, 32'h1, 32'h1, 8'h1);
      run_window(3, 100, 0);
      exp_err = exp_err + 1;
      n_cmp++;
      if (tw_cnt !== 0 || aw_cnt !== 0 || lb_at[1] !== 1'b0) begin
         n_fail++; $display("FAIL reserved_no_write: got tw %0d aw %0d busy %b required 0 0 0", tw_cnt, aw_cnt, lb_at[1]);
      end
      n_cmp++;
      if (err_count !== exp_err || rdy_at[1] !== 1'b1) begin
         n_fail++; $display("FAIL reserved_err: got err %0d ready %b required %0d 1", err_count, rdy_at[1], exp_err);
      end
   endtask

   task automatic test_busy_in_idle();
      tcam_busy = 1'b1;
      n_cmp++;
      if (s_cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL busy_idle_ready: got %b required 1", s_cmd_ready);
      end
      issue_cmd(2'b00, 4'd6, 32'hc0a80001, 32'hffff0000, 8'h11);
      run_window(8, 1, 2);
      exp_wr = exp_wr + 1;
      n_cmp++;
      if (tw_first !== 1 || aw_first !== 4 || wr_count !== exp_wr) begin
         n_fail++; $display("FAIL busy_idle_entry: got tcam %0d action %0d wr %0d required 1 4 %0d",
                            tw_first, aw_first, wr_count, exp_wr);
      end
   endtask

   task automatic test_stuck_busy();
      issue_cmd(2'b00, 4'd1, 32'h0000abcd, 32'hffffffff, 8'h22);
      run_window(70, 1, 1000);
`ifdef FLOW_LOADER_TIMEOUT_EN
      exp_err = exp_err + 1;
      n_cmp++;
      if (aw_cnt !== 0 || lb_at[66] !== 1'b1 || lb_at[67] !== 1'b0) begin
         n_fail++; $display("FAIL timeout_exit: got aw %0d busy66 %b busy67 %b required 0 1 0",
                            aw_cnt, lb_at[66], lb_at[67]);
      end
      n_cmp++;
      if (err_count !== exp_err || wr_count !== exp_wr) begin
         n_fail++; $display("FAIL timeout_counts: got err %0d wr %0d required %0d %0d",
                            err_count, wr_count, exp_err, exp_wr);
      end
`else
      n_cmp++;
      if (aw_cnt !== 0 || lb_at[70] !== 1'b1 || ctrl_at[70] !== 2'b01) begin
         n_fail++; $display("FAIL stuck_wait: got aw %0d busy %b ctrl %b required 0 1 01",
                            aw_cnt, lb_at[70], ctrl_at[70]);
      end
      n_cmp++;
      if (err_count !== exp_err || wr_count !== exp_wr) begin
         n_fail++; $display("FAIL stuck_counts: got err %0d wr %0d required %0d %0d",
                            err_count, wr_count, exp_err, exp_wr);
      end
`endif
   endtask

   task automatic test_reset_mid_wait();
`ifdef FLOW_LOADER_TIMEOUT_EN
      // Park the FSM in T_WAIT again; the timeout build left it idle.
      issue_cmd(2'b00, 4'd2, 32'h5, 32'h5, 8'h5);
      run_window(3, 1, 1000);
`endif
      n_cmp++;
      if (loader_busy !== 1'b1 || flow_buffer_sel !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_state: got busy %b sel %b required 1 1", loader_busy, flow_buffer_sel);
      end
      #2;
      axi_resetn = 1'b0;
      #1;
      n_cmp++;
      if ({loader_busy, s_cmd_ready, tcam_wren, action_wren, tcam_wr_ctrl, action_wr_ctrl,
           flow_buffer_sel, tcam_addr_wr} !== 13'b0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got busy %b rdy %b ctrl %b %b sel %b addr %h required all 0",
                            loader_busy, s_cmd_ready, tcam_wr_ctrl, action_wr_ctrl, flow_buffer_sel, tcam_addr_wr);
      end
      n_cmp++;
      if (wr_count !== '0 || err_count !== '0) begin
         n_fail++; $display("FAIL reset_mid_counts: got wr %0d err %0d required 0 0", wr_count, err_count);
      end
      exp_wr    = '0;
      exp_err   = '0;
      tcam_busy = 1'b0;
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      @(posedge axi_aclk);
      #1;
      issue_cmd(2'b10, 4'd7, 32'h0, 32'h0, 8'h33);
      run_window(4, 100, 0);
      exp_wr = exp_wr + 1;
      n_cmp++;
      if (aw_first !== 1 || tw_cnt !== 0 || {aw_addr, aw_din} !== {4'd7, 8'h33} || wr_count !== exp_wr) begin
         n_fail++; $display("FAIL reset_mid_recover: got aw@%0d tw %0d %h %h wr %0d required 1 0 7 33 %0d",
                            aw_first, tw_cnt, aw_addr, aw_din, wr_count, exp_wr);
      end
   endtask

   initial begin
      test_reset();
      test_entry_write();
      test_entry_latency();
      test_action_only();
      test_commit();
      test_reserved();
      test_busy_in_idle();
      test_stuck_busy();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard stop if the sequence above ever fails to complete.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
